// File: rtl/kypd_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner: geometry, key map
// and the scan state encoding.
package kypd_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Indexed {col, row}; rows within a column are consecutive entries.
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    typedef enum logic {
        DRIVE = 1'b0,
        EVAL  = 1'b1
    } scan_state_t;

    // Lowest-numbered active-low row; only meaningful when some row is low.
    function automatic logic [1:0] first_low(input logic [3:0] rows);
        if (!rows[0])      return 2'd0;
        else if (!rows[1]) return 2'd1;
        else if (!rows[2]) return 2'd2;
        else               return 2'd3;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Multi-bit flop-chain synchronizer for asynchronous inputs; resets to all-ones
// so idle pulled-up lines read as inactive straight out of reset.
module synchronizer #(
    parameter int WIDTH        = 1,
    parameter int CHAIN_LENGTH = 2
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             clk_en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] chain_q [CHAIN_LENGTH];

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < CHAIN_LENGTH; i++) chain_q[i] <= '1;
        end else if (clk_en_i) begin
            chain_q[0] <= d_i;
            for (int i = 1; i < CHAIN_LENGTH; i++) chain_q[i] <= chain_q[i-1];
        end
    end

    assign q_o = chain_q[CHAIN_LENGTH-1];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column-at-a-time drive, whole-scan debounce,
// hex key code with a single-cycle press strobe and a held level.
module keypad_scanner
    import kypd_pkg::*;
#(
    parameter int SETTLE_TICKS   = 2,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       clk_en_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_TICKS - 1);
    localparam logic [3:0] DEB_FULL    = 4'(DEBOUNCE_SCANS);

    logic [NUM_ROWS-1:0]         rows_p2;
    scan_state_t                 state, state_next;
    logic [$clog2(NUM_COLS)-1:0] col_idx;
    logic [3:0]                  settle_cnt;
    logic                        sample_now;
    logic                        hit_found;
    logic [3:0]                  hit_code;
    logic                        cand_valid;
    logic [3:0]                  cand_code;
    logic [3:0]                  deb_cnt, deb_next;
    logic [3:0]                  nokey_cnt, nokey_next;
    logic                        held_kept;
    logic                        accept;

    synchronizer #(
        .WIDTH        (NUM_ROWS),
        .CHAIN_LENGTH (2)
    ) u_row_sync (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clk_en_i (1'b1),
        .d_i      (row_i),
        .q_o      (rows_p2)
    );

    assign sample_now = (state == DRIVE) && (settle_cnt == SETTLE_LAST);

    always_ff @(posedge clk_i) begin
        if (!reset_ni)     state <= DRIVE;
        else if (clk_en_i) state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DRIVE:   if (sample_now && col_idx == 2'd3) state_next = EVAL;
            EVAL:    state_next = DRIVE;
            default: state_next = DRIVE;
        endcase
    end

    always_comb begin
        col_o = ~(4'b0001 << col_idx);
    end

    // Column walk and per-scan hit capture; the first hit of a scan wins.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            col_idx    <= '0;
            settle_cnt <= '0;
            hit_found  <= 1'b0;
            hit_code   <= 4'h0;
        end else if (clk_en_i) begin
            if (state == EVAL) begin
                hit_found <= 1'b0;
                hit_code  <= 4'h0;
            end else if (sample_now) begin
                settle_cnt <= '0;
                col_idx    <= col_idx + 2'd1;
                if (!hit_found && rows_p2 != 4'hF) begin
                    hit_found <= 1'b1;
                    hit_code  <= KEYMAP[{col_idx, first_low(rows_p2)}];
                end
            end else begin
                settle_cnt <= settle_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        deb_next   = 4'd0;
        nokey_next = (nokey_cnt >= DEB_FULL) ? DEB_FULL : nokey_cnt + 4'd1;
        if (hit_found) begin
            if (cand_valid && hit_code == cand_code)
                deb_next = (deb_cnt >= DEB_FULL) ? DEB_FULL : deb_cnt + 4'd1;
            else
                deb_next = 4'd1;
        end
        // A brief release of the accepted key must not re-arm the strobe.
        held_kept = key_held_o && !(hit_found && hit_code != key_o);
        accept    = hit_found && (deb_next == DEB_FULL) && !held_kept;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            cand_valid  <= 1'b0;
            cand_code   <= 4'h0;
            deb_cnt     <= 4'd0;
            nokey_cnt   <= 4'd0;
            key_o       <= 4'h0;
            key_held_o  <= 1'b0;
            key_valid_o <= 1'b0;
        end else begin
            key_valid_o <= 1'b0;
            if (clk_en_i && state == EVAL) begin
                deb_cnt <= deb_next;
                if (hit_found) begin
                    cand_valid <= 1'b1;
                    cand_code  <= hit_code;
                    nokey_cnt  <= 4'd0;
                    key_held_o <= held_kept;
                    if (accept) begin
                        key_o       <= hit_code;
                        key_held_o  <= 1'b1;
                        key_valid_o <= 1'b1;
                    end
                end else begin
                    cand_valid <= 1'b0;
                    cand_code  <= 4'h0;
                    nokey_cnt  <= nokey_next;
                    if (nokey_next == DEB_FULL) key_held_o <= 1'b0;
                end
            end
        end
    end

    a_settle_range: assert property (@(posedge clk_i) SETTLE_TICKS >= 1 && SETTLE_TICKS <= 15);
    a_deb_range:    assert property (@(posedge clk_i) DEBOUNCE_SCANS >= 1 && DEBOUNCE_SCANS <= 15);
    a_col_onecold:  assert property (@(posedge clk_i) $onehot(~col_o));

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model answers the column drive,
// directed presses queue expected strobes, and a monitor checks each strobe.
module tb_keypad_scanner;

    logic       clk_i;
    logic       reset_ni;
    logic       clk_en_i;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_o;
    logic       key_valid_o;
    logic       key_held_o;

    logic [15:0] pressed;   // bit r*4+c
    int          ticks;
    int          cyc;
    int          n_checks;
    int          n_fail;

    typedef struct {
        logic [3:0] key;
        int         scan;
    } exp_t;
    exp_t exp_q[$];

    localparam int TPS = 9;  // ticks per scan
    localparam int K1 = 0, K5 = 5, K7 = 8, K9 = 10, KD = 15;

    keypad_scanner #(
        .SETTLE_TICKS   (2),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .clk_en_i    (clk_en_i),
        .row_i       (row_i),
        .col_o       (col_o),
        .key_o       (key_o),
        .key_valid_o (key_valid_o),
        .key_held_o  (key_held_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        clk_en_i = 1'b0;
        cyc      = 0;
        forever begin
            @(negedge clk_i);
            cyc++;
            clk_en_i = (cyc % 4 == 0);
        end
    end

    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
    end

    always @(posedge clk_i) begin
        if (!reset_ni)     ticks <= 0;
        else if (clk_en_i) ticks <= ticks + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ticks(input int t);
        int budget;
        budget = 4000;
        while (ticks < t && budget > 0) begin
            @(negedge clk_i);
            budget--;
        end
        if (budget == 0) chk("wait_timeout", 32'(ticks), 32'(t));
    endtask

    task automatic goto_scan(input int s);
        wait_ticks(s * TPS);
    endtask

    task automatic expect_press(input logic [3:0] key, input int scan);
        exp_t e;
        e.key  = key;
        e.scan = scan;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_col"},   32'(col_o),       32'hE);
        chk({tag, "_key"},   32'(key_o),       32'h0);
        chk({tag, "_valid"}, 32'(key_valid_o), 32'h0);
        chk({tag, "_held"},  32'(key_held_o),  32'h0);
    endtask

    // Strobe monitor: every key_valid_o cycle must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (key_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'(key_o), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_key",  32'(key_o),     32'(e.key));
                    chk("pulse_scan", 32'(ticks / TPS), 32'(e.scan));
                    chk("pulse_held", 32'(key_held_o), 32'h1);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pressed  = '0;
        reset_ni = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset");
        reset_ni = 1'b1;

        for (int t = 0; t < 8; t++) begin
            wait_ticks(t);
            chk($sformatf("col_tick%0d", t), 32'(col_o), 32'(4'(~(4'b0001 << (t / 2)))));
        end

        // '5' held continuously: one strobe after three scans, none afterwards.
        goto_scan(1);
        pressed[K5] = 1'b1;
        expect_press(4'h5, 4);
        goto_scan(5);
        chk("held5_early", 32'(key_held_o), 32'h1);
        goto_scan(14);
        chk("held5_late", 32'(key_held_o), 32'h1);
        pressed[K5] = 1'b0;
        goto_scan(16);
        chk("held5_two_empty", 32'(key_held_o), 32'h1);
        goto_scan(17);
        chk("held5_released", 32'(key_held_o), 32'h0);
        chk("key5_kept", 32'(key_o), 32'h5);

        // '9' bounces: 2 scans on, 1 off, 3 on.
        pressed[K9] = 1'b1;
        goto_scan(19);
        pressed[K9] = 1'b0;
        goto_scan(20);
        pressed[K9] = 1'b1;
        expect_press(4'h9, 23);
        goto_scan(22);
        chk("held9_before", 32'(key_held_o), 32'h0);
        goto_scan(23);
        pressed[K9] = 1'b0;
        goto_scan(26);
        chk("held9_released", 32'(key_held_o), 32'h0);

        // '1' and 'D' together, then '1' lifted.
        pressed[K1] = 1'b1;
        pressed[KD] = 1'b1;
        expect_press(4'h1, 29);
        goto_scan(30);
        chk("held1", 32'(key_held_o), 32'h1);
        pressed[K1] = 1'b0;
        expect_press(4'hD, 33);
        goto_scan(31);
        chk("held_drop_on_d", 32'(key_held_o), 32'h0);
        chk("key_still_1", 32'(key_o), 32'h1);
        goto_scan(34);
        pressed[KD] = 1'b0;
        goto_scan(37);
        chk("heldD_released", 32'(key_held_o), 32'h0);

        // '7' pressed for two scans, then reset discards the partial debounce.
        pressed[K7] = 1'b1;
        goto_scan(39);
        reset_ni = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("midreset");
        reset_ni = 1'b1;
        expect_press(4'h7, 3);
        goto_scan(3);
        chk("held7", 32'(key_held_o), 32'h1);
        goto_scan(5);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
